pwm_fader: RTL and testbench
============================

Name: pwm_fader

Overview:
- Ramp sequencer for the PWM block's duty-cycle register: moves the PWM duty from its current value to a programmed target in fixed steps at a programmable tick interval.
- Sits between the CSR bus and the PWM block's CSR port.
- Owns its own CSR registers and issues its own duty writes to the PWM.
- Shares the PWM CSR port with host writes (host has priority); raises a done interrupt.

Parameters:
- BASE_ADDR, 5'h10, CSR address of the fader's own register window (5 registers).
- PWM_BASE_ADDR, 5'h08, CSR base of the PWM block; the duty register is at PWM_BASE_ADDR+1, bits [6:0].

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- csr_a  in  5  host CSR address
- csr_di  in  8  host CSR write data
- csr_we  in  1  host CSR write strobe
- csr_do  out  8  read data for fader registers; 0 for any other address
- tick_ce  in  1  one-cycle step-timebase enable
- pwm_csr_a  out  5  address to PWM block
- pwm_csr_di  out  8  write data to PWM block
- pwm_csr_we  out  1  write strobe to PWM block
- busy  out  1  ramp in progress (state != IDLE)
- irq  out  1  DONE & IRQ_EN

Behaviour:
- Registers at BASE_ADDR+n; all reset to 0:
  - +0 CTRL: [7] EN, [6] IRQ_EN, [1] BUSY (read-only), [0] DONE (write 1 to clear).
  - +1 TARGET [6:0].
  - +2 STEP [3:0]; value 0 is treated as 1.
  - +3 INTERVAL [7:0].
  - +4 CURRENT [6:0], read-only.
  - Unused bits read 0.
- CURRENT mirrors the duty the PWM holds.
  - Updated on every fader write issued to the PWM.
  - Updated on every host write to PWM_BASE_ADDR+1 (snoop: CURRENT <= csr_di[6:0]).
- PWM port mux is combinational:
  - When csr_we=1, the host bus passes through unchanged.
  - Otherwise the fader drives it: pwm_csr_we=1 only in WRITE state, with a=PWM_BASE_ADDR+1 and di={1'b0,NEXT}.
  - When the fader is not driving, pwm_csr_a = csr_a, pwm_csr_di = csr_di, pwm_csr_we = 0.
- FSM states: IDLE, WAIT, WRITE.
  - IDLE: if EN and CURRENT != TARGET, load cnt <= INTERVAL and go to WAIT.
  - WAIT: on tick_ce with cnt != 0, decrement cnt. On tick_ce with cnt == 0:
    - NEXT <= TARGET if |TARGET-CURRENT| <= STEP.
    - Otherwise NEXT <= CURRENT ± STEP, toward TARGET.
    - Go to WRITE.
    - Each step therefore takes INTERVAL+1 ticks.
  - WRITE: if csr_we=0, issue the write this cycle and set CURRENT <= NEXT. Then:
    - if NEXT == TARGET: set DONE and go to IDLE;
    - else reload cnt and go to WAIT.
  - WRITE with csr_we=1: host wins; stall in WRITE, no write issued.
- Arithmetic is 7-bit unsigned. Compare before add/subtract, so there is no wrap below 0 or above 127.
- TARGET is sampled at each step computation; a TARGET change mid-ramp retargets at the next step.
  - If CURRENT == TARGET at that point: no write; DONE is set and the FSM returns to IDLE.
- EN cleared in any state:
  - next cycle is IDLE;
  - a pending WRITE is dropped;
  - CURRENT is unchanged and DONE is not set.
- Host snoop write during WAIT updates CURRENT; the next step is computed from the new value.
- Snoop and fader write in the same cycle cannot occur, because host priority suppresses the fader write.
- DONE set and a W1C in the same cycle: set wins.
- EN=1 with CURRENT == TARGET: stays IDLE, DONE untouched.
- tick_ce with INTERVAL=0 every cycle: minimum 2 cycles per step (WAIT→WRITE→WAIT).
- Asynchronous reset mid-ramp:
  - all registers 0, FSM IDLE;
  - outputs busy=0, irq=0, pwm_csr_we=csr_we (passthrough);
  - CURRENT=0, matching the PWM reset duty.

Decomposition:
- Shared package constants:
  - register offsets (CTRL=0, TARGET=1, STEP=2, INTERVAL=3, CURRENT=4);
  - CTRL bit positions;
  - FSM state encoding;
  - PWM duty offset (1).
- Natural sub-module: pwm_fader_step. Combinational next-duty computation from CURRENT, TARGET and STEP, returning NEXT and an at_target flag.

Test Plan:
- Ramp up. Setup: STEP=4, INTERVAL=0, tick_ce=1, TARGET=10, EN=1. Required: PWM duty writes 4, 8, 10 in order; DONE=1; irq=1 with IRQ_EN=1; busy=0 after the last write.
- Ramp down with interval. Setup: CURRENT=20 (via snoop), TARGET=5, STEP=7, INTERVAL=2. Required: writes 13, 6, 5, each 3 ticks apart; STEP=0 with TARGET=7 from 5 gives writes 6, 7.
- Collision. Hold csr_we=1 (host write to an unrelated address) during WRITE for 3 cycles. Required: host passes through; fader write is issued in the cycle after csr_we drops, with the correct data.
- Snoop and retarget. During WAIT, host writes 50 to PWM duty and TARGET is changed to 40 (STEP=4). Required: next fader write is 46.
- Abort. Clear EN while in WRITE with csr_we held. Required: no fader write; CURRENT unchanged; DONE=0; FSM IDLE.
- Reset mid-ramp. Assert rst asynchronously between clock edges. Required: busy=0, irq=0, all registers read 0 immediately, no fader write after release.

Source files
------------

// File: rtl/pwm_fader_pkg.sv
// Shared register map, CTRL bit layout, FSM encoding and step helper for the PWM duty fader.
// Pure declarations: no timing or flow control of its own.
package pwm_fader_pkg;

    localparam logic [4:0] REG_CTRL     = 5'd0;
    localparam logic [4:0] REG_TARGET   = 5'd1;
    localparam logic [4:0] REG_STEP     = 5'd2;
    localparam logic [4:0] REG_INTERVAL = 5'd3;
    localparam logic [4:0] REG_CURRENT  = 5'd4;
    localparam logic [4:0] REG_COUNT    = 5'd5;

    localparam int CTRL_EN     = 7;
    localparam int CTRL_IRQ_EN = 6;
    localparam int CTRL_BUSY   = 1;
    localparam int CTRL_DONE   = 0;

    localparam logic [4:0] PWM_DUTY_OFS = 5'd1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_WAIT  = 2'b01,
        ST_WRITE = 2'b10
    } state_t;

    typedef struct packed {
        logic en;
        logic irq_en;
        logic done;
    } ctrl_t;

    // A programmed step of 0 would stall the ramp forever, so it behaves as 1.
    function automatic logic [3:0] eff_step(input logic [3:0] step);
        return (step == 4'd0) ? 4'd1 : step;
    endfunction

endpackage

// File: rtl/pwm_fader_step.sv
// Next-duty computation: moves current toward target by at most one step, clamping at target.
// Purely combinational, zero latency, no flow control.
module pwm_fader_step
    import pwm_fader_pkg::*;
(
    input  logic [6:0] current,
    input  logic [6:0] target,
    input  logic [3:0] step,
    output logic [6:0] next,
    output logic       at_target
);

    logic [6:0] step_ext;
    logic [6:0] diff;
    logic       up;

    // Distance is compared before any add/subtract, so the result never wraps past 0 or 127.
    always_comb begin
        step_ext  = {3'b000, eff_step(step)};
        up        = target > current;
        diff      = up ? (target - current) : (current - target);
        at_target = (current == target);
        next      = target;
        if (!at_target && (diff > step_ext)) begin
            next = up ? (current + step_ext) : (current - step_ext);
        end
    end

endmodule

// File: rtl/pwm_fader.sv
// Ramps the PWM duty register toward a programmed target, one step per INTERVAL+1 ticks.
// One-cycle write issue from WRITE state; host CSR writes always win and stall the fader.
module pwm_fader
    import pwm_fader_pkg::*;
#(
    parameter logic [4:0] BASE_ADDR     = 5'h10,
    parameter logic [4:0] PWM_BASE_ADDR = 5'h08
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] csr_a,
    input  logic [7:0] csr_di,
    input  logic       csr_we,
    output logic [7:0] csr_do,
    input  logic       tick_ce,
    output logic [4:0] pwm_csr_a,
    output logic [7:0] pwm_csr_di,
    output logic       pwm_csr_we,
    output logic       busy,
    output logic       irq
);

    localparam logic [4:0] DUTY_ADDR = PWM_BASE_ADDR + PWM_DUTY_OFS;

    state_t     state_q;
    state_t     state_d;
    ctrl_t      ctrl_q;
    logic [6:0] target_q;
    logic [6:0] current_q;
    logic [6:0] next_q;
    logic [6:0] step_next;
    logic [3:0] step_q;
    logic [7:0] interval_q;
    logic [7:0] cnt_q;
    logic [4:0] reg_ofs;
    logic       reg_hit;
    logic       reg_wr;
    logic       ctrl_wr;
    logic       duty_snoop;
    logic       en_eff;
    logic       step_at_target;
    logic       load_cnt;
    logic       dec_cnt;
    logic       load_next;
    logic       fader_we;
    logic       set_done;

    assign reg_ofs    = csr_a - BASE_ADDR;
    assign reg_hit    = (reg_ofs < REG_COUNT);
    assign reg_wr     = csr_we && reg_hit;
    assign ctrl_wr    = reg_wr && (reg_ofs == REG_CTRL);
    assign duty_snoop = csr_we && (csr_a == DUTY_ADDR);

    // Clearing EN takes effect on the write itself, so the FSM is IDLE the very next cycle.
    assign en_eff = ctrl_wr ? csr_di[CTRL_EN] : ctrl_q.en;

    pwm_fader_step u_step (
        .current   (current_q),
        .target    (target_q),
        .step      (step_q),
        .next      (step_next),
        .at_target (step_at_target)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        load_cnt  = 1'b0;
        dec_cnt   = 1'b0;
        load_next = 1'b0;
        fader_we  = 1'b0;
        set_done  = 1'b0;
        if (!en_eff) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!step_at_target) begin
                        load_cnt = 1'b1;
                        state_d  = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (tick_ce) begin
                        if (cnt_q != 8'd0) begin
                            dec_cnt = 1'b1;
                        end else if (step_at_target) begin
                            // Target was moved onto the current duty mid-ramp: finish without a write.
                            set_done = 1'b1;
                            state_d  = ST_IDLE;
                        end else begin
                            load_next = 1'b1;
                            state_d   = ST_WRITE;
                        end
                    end
                end
                ST_WRITE: begin
                    if (!csr_we) begin
                        fader_we = 1'b1;
                        if (next_q == target_q) begin
                            set_done = 1'b1;
                            state_d  = ST_IDLE;
                        end else begin
                            load_cnt = 1'b1;
                            state_d  = ST_WAIT;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            next_q <= '0;
        end else begin
            if (load_cnt) begin
                cnt_q <= interval_q;
            end else if (dec_cnt) begin
                cnt_q <= cnt_q - 8'd1;
            end
            if (load_next) begin
                next_q <= step_next;
            end
        end
    end

    // Host snoop and fader write are mutually exclusive: a host write suppresses the fader.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            current_q <= '0;
        end else if (fader_we) begin
            current_q <= next_q;
        end else if (duty_snoop) begin
            current_q <= csr_di[6:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            target_q   <= '0;
            step_q     <= '0;
            interval_q <= '0;
        end else if (reg_wr) begin
            case (reg_ofs)
                REG_TARGET:   target_q   <= csr_di[6:0];
                REG_STEP:     step_q     <= csr_di[3:0];
                REG_INTERVAL: interval_q <= csr_di;
                default:      ;
            endcase
        end
    end

    // A completion in the same cycle as a DONE clear keeps DONE set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q <= '0;
        end else begin
            if (ctrl_wr) begin
                ctrl_q.en     <= csr_di[CTRL_EN];
                ctrl_q.irq_en <= csr_di[CTRL_IRQ_EN];
            end
            if (set_done) begin
                ctrl_q.done <= 1'b1;
            end else if (ctrl_wr && csr_di[CTRL_DONE]) begin
                ctrl_q.done <= 1'b0;
            end
        end
    end

    always_comb begin
        csr_do = '0;
        if (reg_hit) begin
            case (reg_ofs)
                REG_CTRL: begin
                    csr_do[CTRL_EN]     = ctrl_q.en;
                    csr_do[CTRL_IRQ_EN] = ctrl_q.irq_en;
                    csr_do[CTRL_BUSY]   = busy;
                    csr_do[CTRL_DONE]   = ctrl_q.done;
                end
                REG_TARGET:   csr_do = {1'b0, target_q};
                REG_STEP:     csr_do = {4'b0000, step_q};
                REG_INTERVAL: csr_do = interval_q;
                REG_CURRENT:  csr_do = {1'b0, current_q};
                default:      csr_do = '0;
            endcase
        end
    end

    assign pwm_csr_we = csr_we | fader_we;
    assign pwm_csr_a  = fader_we ? DUTY_ADDR : csr_a;
    assign pwm_csr_di = fader_we ? {1'b0, next_q} : csr_di;

    assign busy = (state_q != ST_IDLE);
    assign irq  = ctrl_q.done & ctrl_q.irq_en;

endmodule

// File: tb/tb_pwm_fader.sv
// Bench for pwm_fader: directed scenarios plus a reference ramp model and a per-cycle PWM port monitor.
module tb_pwm_fader;

    localparam logic [4:0] BASE    = 5'h10;
    localparam logic [4:0] DUTY_A  = 5'h09;
    localparam logic [4:0] A_CTRL  = BASE;
    localparam logic [4:0] A_TGT   = BASE + 5'd1;
    localparam logic [4:0] A_STEP  = BASE + 5'd2;
    localparam logic [4:0] A_INTV  = BASE + 5'd3;
    localparam logic [4:0] A_CUR   = BASE + 5'd4;
    localparam logic [4:0] A_OTHER = 5'h03;

    logic       clk;
    logic       rst;
    logic [4:0] csr_a;
    logic [7:0] csr_di;
    logic       csr_we;
    logic [7:0] csr_do;
    logic       tick_ce;
    logic [4:0] pwm_csr_a;
    logic [7:0] pwm_csr_di;
    logic       pwm_csr_we;
    logic       busy;
    logic       irq;

    int total;
    int bad;
    int exp_q[$];
    int planned[$];
    int model_duty;
    int tick_mode;
    bit tick_phase;
    int ticks;
    int wr_cnt;
    int wr_base;
    int gap_log[256];

    pwm_fader #(
        .BASE_ADDR     (5'h10),
        .PWM_BASE_ADDR (5'h08)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .csr_a      (csr_a),
        .csr_di     (csr_di),
        .csr_we     (csr_we),
        .csr_do     (csr_do),
        .tick_ce    (tick_ce),
        .pwm_csr_a  (pwm_csr_a),
        .pwm_csr_di (pwm_csr_di),
        .pwm_csr_we (pwm_csr_we),
        .busy       (busy),
        .irq        (irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference ramp: the duty sequence a fader must produce going from cur to tgt.
    function automatic void plan_ramp(input int cur, input int tgt, input int stp);
        int s;
        int d;
        s = (stp == 0) ? 1 : stp;
        d = cur;
        planned.delete();
        while (d != tgt) begin
            if (tgt > d) d = ((tgt - d) <= s) ? tgt : d + s;
            else         d = ((d - tgt) <= s) ? tgt : d - s;
            planned.push_back(d);
            exp_q.push_back(d);
        end
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
        tick_phase = ~tick_phase;
        case (tick_mode)
            0:       tick_ce = 1'b0;
            1:       tick_ce = 1'b1;
            default: tick_ce = tick_phase;
        endcase
    endtask

    task automatic csr_write(input logic [4:0] a, input logic [7:0] d);
        csr_a  = a;
        csr_di = d;
        csr_we = 1'b1;
        cycle();
        csr_we = 1'b0;
    endtask

    task automatic csr_read(input string name, input logic [4:0] a, input int exp);
        csr_a = a;
        @(negedge clk);
        check(name, csr_do, exp);
        cycle();
    endtask

    task automatic wait_ramp(input string name, input int max_cycles);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < max_cycles) begin
            cycle();
            n++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_timeout: %0d writes still pending after %0d cycles", name, exp_q.size(), n);
        end
        check({name, "_busy_after_last"}, busy, 0);
    endtask

    // PWM port monitor: host passthrough, fader write data against the model queue, duty tracking.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                model_duty = 0;
            end else if (csr_we) begin
                check("pass_we", pwm_csr_we, 1);
                check("pass_a", pwm_csr_a, csr_a);
                check("pass_di", pwm_csr_di, csr_di);
                if (csr_a == DUTY_A) model_duty = csr_di[6:0];
                if (tick_ce) ticks++;
            end else if (pwm_csr_we) begin
                check("fw_addr", pwm_csr_a, DUTY_A);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL fw_unexpected: got write of %0d, expected no fader write", pwm_csr_di);
                end else begin
                    check("fw_data", pwm_csr_di, exp_q.pop_front());
                end
                model_duty = pwm_csr_di[6:0];
                if (wr_cnt < 256) gap_log[wr_cnt] = ticks;
                wr_cnt++;
                ticks = 0;
            end else begin
                check("idle_a", pwm_csr_a, csr_a);
                check("idle_di", pwm_csr_di, csr_di);
                if (tick_ce) ticks++;
            end
        end
    end

    initial begin
        rst       = 1'b1;
        csr_a     = '0;
        csr_di    = '0;
        csr_we    = 1'b0;
        tick_ce   = 1'b0;
        tick_mode = 0;
        repeat (3) cycle();
        check("rst_busy", busy, 0);
        check("rst_irq", irq, 0);
        check("rst_pwm_we", pwm_csr_we, 0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) csr_read("rst_reg", BASE + 5'(i), 0);

        // Ramp up 0 -> 10 in steps of 4, one tick per step.
        csr_write(A_STEP, 8'd4);
        csr_write(A_INTV, 8'd0);
        csr_write(A_TGT, 8'd10);
        tick_mode = 1;
        plan_ramp(model_duty, 10, 4);
        check("up_plan_len", planned.size(), 3);
        check("up_plan_0", planned[0], 4);
        check("up_plan_1", planned[1], 8);
        check("up_plan_2", planned[2], 10);
        csr_write(A_CTRL, 8'hC0);
        wait_ramp("up", 100);
        check("up_irq", irq, 1);
        csr_read("up_ctrl", A_CTRL, 8'hC1);
        csr_read("up_current", A_CUR, 10);
        check("up_model_duty", model_duty, 10);
        csr_write(A_CTRL, 8'hC1);
        check("up_irq_cleared", irq, 0);

        // Ramp down 20 -> 5, step 7, INTERVAL 2, ticks on alternate cycles.
        csr_write(A_CTRL, 8'h00);
        csr_write(DUTY_A, 8'd20);
        csr_read("dn_snoop_cur", A_CUR, 20);
        csr_write(A_TGT, 8'd5);
        csr_write(A_STEP, 8'd7);
        csr_write(A_INTV, 8'd2);
        tick_mode = 2;
        plan_ramp(model_duty, 5, 7);
        check("dn_plan_0", planned[0], 13);
        check("dn_plan_1", planned[1], 6);
        check("dn_plan_2", planned[2], 5);
        wr_base = wr_cnt;
        csr_write(A_CTRL, 8'hC0);
        wait_ramp("dn", 200);
        check("dn_gap_1", gap_log[wr_base + 1], 3);
        check("dn_gap_2", gap_log[wr_base + 2], 3);
        check("dn_irq", irq, 1);
        csr_write(A_CTRL, 8'hC1);
        csr_write(A_STEP, 8'd0);
        plan_ramp(model_duty, 7, 0);
        check("s0_plan_len", planned.size(), 2);
        check("s0_plan_0", planned[0], 6);
        csr_write(A_TGT, 8'd7);
        wait_ramp("s0", 200);
        csr_read("s0_current", A_CUR, 7);

        // Collision: host holds the bus for 3 cycles while the fader sits in WRITE.
        csr_write(A_CTRL, 8'hC1);
        tick_mode = 0;
        csr_write(A_INTV, 8'd0);
        csr_write(A_STEP, 8'd4);
        plan_ramp(model_duty, 15, 4);
        check("col_plan_0", planned[0], 11);
        csr_write(A_TGT, 8'd15);
        cycle();
        tick_ce = 1'b1;
        cycle();
        csr_a  = A_OTHER;
        csr_di = 8'h5A;
        csr_we = 1'b1;
        repeat (3) begin
            cycle();
            check("col_busy_held", busy, 1);
        end
        csr_we = 1'b0;
        @(negedge clk);
        check("col_release_we", pwm_csr_we, 1);
        check("col_release_a", pwm_csr_a, DUTY_A);
        check("col_release_di", pwm_csr_di, 11);
        tick_mode = 1;
        cycle();
        wait_ramp("col", 100);
        csr_read("col_current", A_CUR, 15);

        // Snoop 50 and retarget to 40 while waiting for a tick.
        csr_write(A_CTRL, 8'hC1);
        tick_mode = 0;
        csr_write(A_TGT, 8'd30);
        cycle();
        cycle();
        check("snp_busy_wait", busy, 1);
        csr_write(DUTY_A, 8'd50);
        csr_write(A_TGT, 8'd40);
        plan_ramp(model_duty, 40, 4);
        check("snp_plan_0", planned[0], 46);
        check("snp_plan_len", planned.size(), 3);
        tick_mode = 1;
        wait_ramp("snp", 100);
        csr_read("snp_current", A_CUR, 40);
        check("snp_irq", irq, 1);

        // Asynchronous reset in the middle of a ramp.
        plan_ramp(model_duty, 100, 4);
        csr_write(A_TGT, 8'd100);
        repeat (5) cycle();
        check("rmr_busy_pre", busy, 1);
        check("rmr_irq_pre", irq, 1);
        #2;
        rst = 1'b1;
        #1;
        check("rmr_busy", busy, 0);
        check("rmr_irq", irq, 0);
        check("rmr_pwm_we", pwm_csr_we, csr_we);
        for (int i = 0; i < 5; i++) begin
            csr_a = BASE + 5'(i);
            #1;
            check("rmr_reg", csr_do, 0);
        end
        exp_q.delete();
        cycle();
        cycle();
        rst = 1'b0;
        repeat (20) cycle();
        check("rmr_busy_post", busy, 0);
        csr_read("rmr_current", A_CUR, 0);

        // Abort: EN cleared by a host write while the fader is stalled in WRITE.
        tick_mode = 0;
        csr_write(DUTY_A, 8'd33);
        csr_write(A_STEP, 8'd4);
        csr_write(A_TGT, 8'd20);
        csr_write(A_CTRL, 8'hC0);
        cycle();
        tick_ce = 1'b1;
        cycle();
        check("abt_busy_pre", busy, 1);
        csr_write(A_CTRL, 8'h00);
        csr_a  = A_OTHER;
        csr_di = 8'h33;
        csr_we = 1'b1;
        @(negedge clk);
        check("abt_idle_next", busy, 0);
        cycle();
        csr_we    = 1'b0;
        tick_mode = 1;
        repeat (10) cycle();
        check("abt_busy", busy, 0);
        check("abt_irq", irq, 0);
        csr_read("abt_current", A_CUR, 33);
        csr_read("abt_ctrl", A_CTRL, 0);
        check("abt_model_duty", model_duty, 33);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
